sakebi_fcs_sequencer: RTL and testbench

- Frame-level controller that sequences an external sakebi_crc32_wrapper instance to build Ethernet frames.
- Passes payload bytes from an upstream AXI-Stream source to a downstream sink and feeds each accepted byte to the CRC engine.
- After TLAST, appends the 4-byte FCS LSB first, then enforces an inter-frame gap.
- Sits between the frame builder and the MAC/PHY byte sink.

---
 rtl/sakebi_fcs_sequencer.sv | 159 +++++++++++++++
 tb/tb_sakebi_fcs_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sakebi_fcs_sequencer.sv
// Ethernet frame sequencer: passes payload to the sink, strobes it into an external CRC-32
// engine, appends the FCS LSB first, then holds an inter-frame gap. Padding: SAKEBI_FCS_PAD_EN.
module sakebi_fcs_sequencer #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_FRAME  = 60
) (
    input  logic        i_axis_ACLK,
    input  logic        i_axis_ARESET,
    input  logic        i_axis_TVALID,
    input  logic [7:0]  i_axis_TDATA,
    input  logic        i_axis_TLAST,
    output logic        o_axis_TREADY,
    output logic        o_axis_TVALID,
    output logic [7:0]  o_axis_TDATA,
    output logic        o_axis_TLAST,
    input  logic        i_axis_TREADY,
    output logic        o_crc_clear,
    output logic        o_crc_valid,
    output logic [7:0]  o_crc_data,
    input  logic [31:0] i_crc_value,
    output logic        o_frame_done
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

    if (IFG_CYCLES < 1 || MIN_FRAME < 1 || MIN_FRAME > 65535) begin : g_cfg_check
        $error("sakebi_fcs_sequencer: IFG_CYCLES must be >= 1 and MIN_FRAME within 1..65535");
    end

`ifdef SAKEBI_FCS_PAD_EN
    localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);
`endif

    typedef enum logic [2:0] {
        ST_GAP,
        ST_IDLE,
        ST_DATA,
`ifdef SAKEBI_FCS_PAD_EN
        ST_PAD,
`endif
        ST_LATCH,
        ST_FCS
    } state_t;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [15:0]      byte_cnt, byte_nxt, byte_upd, cnt_inc;
    logic [31:0]      fcs_reg, fcs_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             hs;

    assign hs      = i_axis_TVALID & i_axis_TREADY;
    assign cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt     = state;
        gap_nxt       = gap_cnt;
        byte_nxt      = byte_cnt;
        byte_upd      = 16'd0;
        fcs_nxt       = fcs_reg;
        idx_nxt       = idx;
        o_axis_TREADY = 1'b0;
        o_axis_TVALID = 1'b0;
        o_axis_TDATA  = 8'h00;
        o_axis_TLAST  = 1'b0;
        o_crc_clear   = 1'b0;
        o_crc_valid   = 1'b0;
        o_crc_data    = 8'h00;
        o_frame_done  = 1'b0;

        case (state)
            ST_GAP: begin
                o_crc_clear = 1'b1;
                if (gap_cnt == '0) state_nxt = ST_IDLE;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end

            ST_IDLE, ST_DATA: begin
                o_axis_TVALID = i_axis_TVALID;
                o_axis_TDATA  = i_axis_TDATA;
                o_axis_TREADY = i_axis_TREADY;
                o_crc_valid   = hs;
                o_crc_data    = i_axis_TDATA;
                if (hs) begin
                    byte_upd = (state == ST_IDLE) ? 16'd1 : cnt_inc;
                    byte_nxt = byte_upd;
                    if (i_axis_TLAST) begin
`ifdef SAKEBI_FCS_PAD_EN
                        state_nxt = (byte_upd < MIN_CNT) ? ST_PAD : ST_LATCH;
`else
                        state_nxt = ST_LATCH;
`endif
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end

`ifdef SAKEBI_FCS_PAD_EN
            ST_PAD: begin
                o_axis_TVALID = 1'b1;
                o_crc_valid   = i_axis_TREADY;
                if (i_axis_TREADY) begin
                    byte_nxt = cnt_inc;
                    if (cnt_inc >= MIN_CNT) state_nxt = ST_LATCH;
                end
            end
`endif

            // The engine needs one cycle after the last strobe before its value is final.
            ST_LATCH: begin
                fcs_nxt   = i_crc_value;
                idx_nxt   = 2'd0;
                state_nxt = ST_FCS;
            end

            ST_FCS: begin
                o_axis_TVALID = 1'b1;
                o_axis_TDATA  = fcs_reg[{idx, 3'b000} +: 8];
                o_axis_TLAST  = (idx == 2'd3);
                if (i_axis_TREADY) begin
                    if (idx == 2'd3) begin
                        o_frame_done = 1'b1;
                        byte_nxt     = 16'd0;
                        gap_nxt      = GAP_LOAD;
                        state_nxt    = ST_GAP;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end

            default: begin
                gap_nxt   = GAP_LOAD;
                state_nxt = ST_GAP;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
        if (i_axis_ARESET) begin
            state    <= ST_GAP;
            gap_cnt  <= GAP_LOAD;
            byte_cnt <= 16'd0;
            fcs_reg  <= 32'd0;
            idx      <= 2'd0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            byte_cnt <= byte_nxt;
            fcs_reg  <= fcs_nxt;
            idx      <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_sakebi_fcs_sequencer.sv
// Bench for sakebi_fcs_sequencer: table vectors, directed corner sequences and random frames
// checked against a frame-level model with a CRC-32 engine stand-in.
module tb_sakebi_fcs_sequencer;

    localparam int IFG  = 12;
    localparam int MINF = 60;
`ifdef SAKEBI_FCS_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_axis_TVALID, i_axis_TLAST, i_axis_TREADY;
    logic [7:0]  i_axis_TDATA;
    logic        o_axis_TREADY, o_axis_TVALID, o_axis_TLAST;
    logic [7:0]  o_axis_TDATA;
    logic        o_crc_clear, o_crc_valid, o_frame_done;
    logic [7:0]  o_crc_data;
    logic [31:0] i_crc_value;

    always #5 clk = ~clk;

    sakebi_fcs_sequencer #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
        .i_axis_ACLK   (clk),
        .i_axis_ARESET (rst),
        .i_axis_TVALID (i_axis_TVALID),
        .i_axis_TDATA  (i_axis_TDATA),
        .i_axis_TLAST  (i_axis_TLAST),
        .o_axis_TREADY (o_axis_TREADY),
        .o_axis_TVALID (o_axis_TVALID),
        .o_axis_TDATA  (o_axis_TDATA),
        .o_axis_TLAST  (o_axis_TLAST),
        .i_axis_TREADY (i_axis_TREADY),
        .o_crc_clear   (o_crc_clear),
        .o_crc_valid   (o_crc_valid),
        .o_crc_data    (o_crc_data),
        .i_crc_value   (i_crc_value),
        .o_frame_done  (o_frame_done)
    );

    // Reflected CRC-32 engine stand-in; value is final one cycle after the last strobe.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [31:0] crc_st;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_val = 32'h0;
    always @(posedge clk or posedge rst) begin
        if (rst)              crc_st <= 32'hFFFFFFFF;
        else if (o_crc_clear) crc_st <= 32'hFFFFFFFF;
        else if (o_crc_valid) crc_st <= crc_upd(crc_st, o_crc_data);
    end
    assign i_crc_value = use_fixed ? fixed_val : ~crc_st;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: downstream beats, CRC strobes, done pulses, and the AXI hold rule.
    logic [8:0] out_q[$];
    logic [7:0] strobe_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int   done_cnt = 0;
    int   frame_done0 = 0;
    int   hold_err = 0;
    bit   hold_chk_en = 1'b1;
    bit   prev_hold = 1'b0;
    logic [8:0] prev_beat;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && hold_chk_en &&
                !(o_axis_TVALID && {o_axis_TLAST, o_axis_TDATA} == prev_beat)) hold_err++;
            prev_hold = o_axis_TVALID && !i_axis_TREADY;
            prev_beat = {o_axis_TLAST, o_axis_TDATA};
            if (o_axis_TVALID && i_axis_TREADY) out_q.push_back({o_axis_TLAST, o_axis_TDATA});
            if (o_crc_valid) strobe_q.push_back(o_crc_data);
            if (o_frame_done) done_cnt++;
        end
    end

    function automatic logic [21:0] outs();
        return {o_axis_TREADY, o_axis_TVALID, o_axis_TDATA, o_axis_TLAST,
                o_crc_clear, o_crc_valid, o_crc_data, o_frame_done};
    endfunction
    localparam logic [21:0] RST_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

    task automatic start_frame();
        out_q.delete();
        strobe_q.delete();
        frame_done0 = done_cnt;
    endtask

    // Drives tx_q[first..] upstream; mode 0: sink always ready, 1: toggling, 2: random.
    task automatic run_frame(input int mode, input int first, input int stop_beats);
        int idx = first;
        int cyc = 0;
        while (done_cnt == frame_done0 && cyc < 3000 &&
               !(stop_beats > 0 && out_q.size() >= stop_beats)) begin
            if (idx < tx_q.size()) begin
                if (!i_axis_TVALID) i_axis_TVALID = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                i_axis_TDATA = tx_q[idx];
                i_axis_TLAST = (idx == tx_q.size() - 1);
            end else begin
                i_axis_TVALID = 1'b0;
                i_axis_TLAST  = 1'b0;
                i_axis_TDATA  = 8'($urandom);
            end
            case (mode)
                0:       i_axis_TREADY = 1'b1;
                1:       i_axis_TREADY = ~i_axis_TREADY;
                default: i_axis_TREADY = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (i_axis_TVALID && o_axis_TREADY) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        i_axis_TVALID = 1'b0;
        i_axis_TLAST  = 1'b0;
        i_axis_TREADY = 1'b1;
    endtask

    // Model: payload, zero pad up to MINF when enabled, then FCS LSB first with TLAST on the end.
    task automatic verify_frame(input string name);
        logic [31:0] c, fcs;
        logic [7:0]  eb;
        int n, total;
        int derr = 0, lerr = 0, serr = 0;
        exp_q = tx_q;
        if (PAD_EN) while (exp_q.size() < MINF) exp_q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (exp_q[i]) c = crc_upd(c, exp_q[i]);
        fcs   = use_fixed ? fixed_val : ~c;
        n     = exp_q.size();
        total = n + 4;
        for (int i = 0; i < out_q.size() && i < total; i++) begin
            eb = (i < n) ? exp_q[i] : 8'(fcs >> (8 * (i - n)));
            if (out_q[i][7:0] !== eb) derr++;
            if (out_q[i][8] !== (i == total - 1)) lerr++;
        end
        for (int i = 0; i < strobe_q.size() && i < n; i++)
            if (strobe_q[i] !== exp_q[i]) serr++;
        check({name, " beat count"},   32'(out_q.size()), 32'(total));
        check({name, " byte errors"},  32'(derr), 32'd0);
        check({name, " tlast errors"}, 32'(lerr), 32'd0);
        check({name, " strobe count"}, 32'(strobe_q.size()), 32'(n));
        check({name, " strobe errors"}, 32'(serr), 32'd0);
        check({name, " done pulses"},  32'(done_cnt - frame_done0), 32'd1);
    endtask

    // Call at posedge+1 right after GAP is entered, with sink ready and no upstream valid.
    task automatic count_gap(input string name);
        int n = 0;
        int clr_bad = 0;
        @(negedge clk);
        while (!o_axis_TREADY && n < 100) begin
            if (!o_crc_clear) clr_bad++;
            n++;
            @(negedge clk);
        end
        check({name, " gap cycles"},     32'(n), 32'(IFG));
        check({name, " clear in gap"},   32'(clr_bad), 32'd0);
        check({name, " ready after gap"}, 32'(o_axis_TREADY), 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       tl;
        logic       tr;
        logic       e_tv;
        logic [7:0] e_td;
        logic       e_tr;
        logic       e_cv;
        logic [7:0] e_cd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] fr8[8];
        int bad, n_pad, tot;

        vecs[0] = '{1'b0, 8'h11, 1'b0, 1'b1,  1'b0, 8'h11, 1'b1, 1'b0, 8'h11};
        vecs[1] = '{1'b1, 8'h33, 1'b0, 1'b0,  1'b1, 8'h33, 1'b0, 1'b0, 8'h33};
        vecs[2] = '{1'b0, 8'h44, 1'b1, 1'b1,  1'b0, 8'h44, 1'b1, 1'b0, 8'h44};
        vecs[3] = '{1'b1, 8'hA5, 1'b1, 1'b0,  1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[4] = '{1'b1, 8'hA5, 1'b0, 1'b1,  1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5};
        vecs[5] = '{1'b1, 8'h5A, 1'b0, 1'b1,  1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[6] = '{1'b0, 8'hFF, 1'b0, 1'b0,  1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF};
        vecs[7] = '{1'b1, 8'h00, 1'b0, 1'b1,  1'b1, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[8] = '{1'b1, 8'hC3, 1'b1, 1'b0,  1'b1, 8'hC3, 1'b0, 1'b0, 8'hC3};
        vecs[9] = '{1'b1, 8'h7E, 1'b0, 1'b1,  1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E};
        fr8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        // Reset state, then release with the sink ready.
        i_axis_TVALID = 1'b1;
        i_axis_TDATA  = 8'h55;
        i_axis_TLAST  = 1'b0;
        i_axis_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'(outs()), 32'(RST_VEC));
        i_axis_TVALID = 1'b0;
        rst = 1'b0;
        count_gap("reset release");

        // Table: pass-through and TLAST ignored without a handshake.
        start_frame();
        tx_q.delete();
        hold_chk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_axis_TVALID = vecs[i].tv;
            i_axis_TDATA  = vecs[i].td;
            i_axis_TLAST  = vecs[i].tl;
            i_axis_TREADY = vecs[i].tr;
            @(negedge clk);
            check($sformatf("table vec %0d", i),
                  32'({o_axis_TVALID, o_axis_TDATA, o_axis_TREADY, o_axis_TLAST,
                       o_crc_valid, o_crc_data, o_frame_done, o_crc_clear}),
                  32'({vecs[i].e_tv, vecs[i].e_td, vecs[i].e_tr, 1'b0,
                       vecs[i].e_cv, vecs[i].e_cd, 1'b0, 1'b0}));
            if (vecs[i].e_cv) tx_q.push_back(vecs[i].td);
            @(posedge clk); #1;
        end
        i_axis_TVALID = 1'b0;
        hold_chk_en = 1'b1;
        tx_q.push_back(8'h99);
        run_frame(0, tx_q.size() - 1, 0);
        verify_frame("table frame");

        // Directed 8-byte frame with a fixed engine value: payload, bubble, FCS, gap.
        use_fixed = 1'b1;
        fixed_val = 32'h12345678;
        start_frame();
        tx_q.delete();
        foreach (fr8[i]) tx_q.push_back(fr8[i]);
        i_axis_TREADY = 1'b1;
        bad = 0;
        while (!o_axis_TREADY && bad < 100) begin
            @(posedge clk); #1;
            bad++;
        end
        bad = 0;
        i_axis_TVALID = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_axis_TDATA = fr8[k];
            i_axis_TLAST = (k == 7);
            @(negedge clk);
            if (!(o_axis_TVALID && o_axis_TREADY && o_axis_TDATA == fr8[k] && !o_axis_TLAST)) bad++;
            @(posedge clk); #1;
        end
        i_axis_TVALID = 1'b0;
        i_axis_TLAST  = 1'b0;
        check("fixed frame payload beats", 32'(bad), 32'd0);
        n_pad = PAD_EN ? MINF - 8 : 0;
        bad = 0;
        for (int k = 0; k < n_pad; k++) begin
            @(negedge clk);
            if (!(o_axis_TVALID && o_axis_TDATA == 8'h00 && o_crc_valid && !o_axis_TREADY)) bad++;
            @(posedge clk); #1;
        end
        check("fixed frame pad beats", 32'(bad), 32'd0);
        @(negedge clk);
        check("latch bubble", 32'({o_axis_TVALID, o_axis_TREADY, o_crc_clear, o_crc_valid}), 32'd0);
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("fcs byte %0d", j),
                  32'({o_axis_TVALID, o_axis_TLAST, o_axis_TDATA, o_frame_done}),
                  32'({1'b1, j == 3, 8'(fixed_val >> (8 * j)), j == 3}));
            @(posedge clk); #1;
        end
        count_gap("fixed frame");
        verify_frame("fixed frame");

        // Same frame, sink toggling every cycle: bytes held until accepted.
        start_frame();
        run_frame(1, 0, 0);
        verify_frame("toggle frame");

        // Single-byte frame.
        use_fixed = 1'b0;
        start_frame();
        tx_q.delete();
        tx_q.push_back(8'hAA);
        run_frame(0, 0, 0);
        verify_frame("one byte frame");

        // Short 10-byte frame: padded to 64 total or 14 without padding.
        start_frame();
        tx_q.delete();
        for (int i = 0; i < 10; i++) tx_q.push_back(8'(i * 17 + 3));
        run_frame(2, 0, 0);
        verify_frame("ten byte frame");
        check("ten byte frame total", 32'(out_q.size()), PAD_EN ? 32'd64 : 32'd14);

        // Random frames against the model.
        for (int f = 0; f < 15; f++) begin
            start_frame();
            tx_q.delete();
            tot = $urandom_range(1, 80);
            for (int i = 0; i < tot; i++) tx_q.push_back(8'($urandom));
            run_frame($urandom_range(0, 2), 0, 0);
            verify_frame($sformatf("random frame %0d", f));
        end

        // Async reset while the FCS is at byte index 2.
        use_fixed = 1'b1;
        fixed_val = 32'hCAFEBABE;
        start_frame();
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'hE0 + i));
        tot = (PAD_EN ? MINF : 4) + 4;
        run_frame(0, 0, tot - 2);
        check("pre-reset fcs idx2", 32'({o_axis_TVALID, o_axis_TLAST, o_axis_TDATA}),
              32'({1'b1, 1'b0, 8'(fixed_val >> 16)}));
        #2;
        rst = 1'b1;
        #1;
        check("mid-fcs reset outputs", 32'(outs()), 32'(RST_VEC));
        check("mid-fcs reset no done", 32'(done_cnt - frame_done0), 32'd0);
        check("mid-fcs reset beats", 32'(out_q.size()), 32'(tot - 2));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_gap("post-reset");
        use_fixed = 1'b0;
        start_frame();
        tx_q.delete();
        for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
        run_frame(2, 0, 0);
        verify_frame("post-reset frame");

        check("axis hold rule", 32'(hold_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
